// File: rtl/ppm_pkg.sv
// Shared types and constants for the PPM byte decoder.
// Build option PPM_SYNC_EN (see ppm_edge_det) adds an input synchronizer.
package ppm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SOF_CHK = 2'd1,
        DATA    = 2'd2
    } ppm_state_e;

    localparam int         SUB_CLKS_DEF  = 16;
    localparam logic [2:0] SOF_SLOT      = 3'd5;
    localparam logic [2:0] EOF_SLOT      = 3'd2;
    localparam int         SYMS_PER_BYTE = 4;

    // Odd sub-slots carry data; later slots encode smaller values.
    function automatic logic [1:0] slot_to_sym(input logic [2:0] slot);
        return ~slot[2:1];
    endfunction

endpackage

// File: rtl/ppm_edge_det.sv
// Samples the PPM line and flags its 1->0 transitions.
// With PPM_SYNC_EN defined, a 2-flop synchronizer precedes the sampling register.
module ppm_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic fall_o
);

    logic din_s;
    logic samp_q;
    logic prev_q;

`ifdef PPM_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din_i};
        end
    end

    assign din_s = sync_q[1];
`else
    assign din_s = din_i;
`endif

    // Both stages reset high so an idle line never produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            samp_q <= din_s;
            prev_q <= samp_q;
        end
    end

    assign fall_o = prev_q & ~samp_q;

endmodule

// File: rtl/ppm_decoder.sv
// 4-PPM decoder: SOF check, 2-bit symbols packed MSB-first into bytes, EOF strobe.
// Define PPM_SYNC_EN to synchronize Din (shifts all strobes by 2 clocks).
module ppm_decoder
    import ppm_pkg::*;
#(
    parameter int SUB_CLKS = SUB_CLKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Din,
    output logic [7:0] Dout,
    output logic       D_en,
    output logic       F_en
);

    localparam int WIN = 8 * SUB_CLKS;
    localparam int CW  = $clog2(WIN);

    ppm_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic        sof_ok_q, sof_ok_d;
    logic [2:0]  sym_cnt_q, sym_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        d_en_q, d_en_d;
    logic        f_en_q, f_en_d;

    logic        fall;
    logic [2:0]  slot;
    logic        win_end;

    ppm_edge_det u_edge (
        .clk    (clk),
        .rst_n  (rst),
        .din_i  (Din),
        .fall_o (fall)
    );

    assign slot    = cnt_q[CW-1 -: 3];
    assign win_end = (cnt_q == CW'(WIN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seen_q    <= 1'b0;
            sof_ok_q  <= 1'b0;
            sym_cnt_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            d_en_q    <= 1'b0;
            f_en_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
            sof_ok_q  <= sof_ok_d;
            sym_cnt_q <= sym_cnt_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            d_en_q    <= d_en_d;
            f_en_q    <= f_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        seen_d    = seen_q;
        sof_ok_d  = sof_ok_q;
        sym_cnt_d = sym_cnt_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        d_en_d    = 1'b0;
        f_en_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The detecting cycle itself counts as offset 0 of the window.
                cnt_d = '0;
                if (fall) begin
                    state_d = SOF_CHK;
                    cnt_d   = CW'(1);
                end
            end

            SOF_CHK: begin
                if (fall && slot != SOF_SLOT) begin
                    state_d = IDLE;
                end else begin
                    if (fall) begin
                        sof_ok_d = 1'b1;
                    end
                    if (win_end) begin
                        state_d = sof_ok_d ? DATA : IDLE;
                    end
                end
            end

            DATA: begin
                if (fall) begin
                    if (seen_q) begin
                        state_d = IDLE;
                    end else if (slot == EOF_SLOT) begin
                        state_d = IDLE;
                        f_en_d  = 1'b1;
                    end else if (slot[0]) begin
                        seen_d    = 1'b1;
                        shift_d   = {shift_q[5:0], slot_to_sym(slot)};
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                if (state_d == DATA && win_end) begin
                    if (!seen_d) begin
                        state_d = IDLE;
                    end else begin
                        seen_d = 1'b0;
                        if (sym_cnt_d == 3'(SYMS_PER_BYTE)) begin
                            dout_d    = shift_d;
                            d_en_d    = 1'b1;
                            sym_cnt_d = '0;
                            shift_d   = '0;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Leaving a frame for any reason drops all partial progress.
        if (state_q != IDLE && state_d == IDLE) begin
            cnt_d     = '0;
            seen_d    = 1'b0;
            sof_ok_d  = 1'b0;
            sym_cnt_d = '0;
            shift_d   = '0;
        end
    end

    assign Dout = dout_q;
    assign D_en = d_en_q;
    assign F_en = f_en_q;

endmodule

// File: tb/tb_ppm_decoder.sv
// Scoreboard bench for ppm_decoder: expected bytes/EOFs are queued as frames are
// driven and matched against the D_en/F_en strobes.
module tb_ppm_decoder;

    localparam int SUB = 16;
    localparam int WIN = 8 * SUB;

    typedef struct {
        bit         is_eof;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       Din;
    logic [7:0] Dout;
    logic       D_en;
    logic       F_en;

    int   total = 0;
    int   bad   = 0;
    int   d_seen = 0;
    int   f_seen = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    ppm_decoder #(.SUB_CLKS(SUB)) dut (
        .clk  (clk),
        .rst  (rst),
        .Din  (Din),
        .Dout (Dout),
        .D_en (D_en),
        .F_en (F_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: every strobe pops and checks the next expected event.
    always @(negedge clk) begin
        if (D_en) begin
            d_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dout_unexpected got=%h expected=none", Dout);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_eof || Dout !== mon_e.data) begin
                    bad++;
                    $display("FAIL dout_byte got=%h required=%h (eof_expected=%0d)", Dout, mon_e.data, mon_e.is_eof);
                end else begin
                    $display("byte  Dout=%h", Dout);
                end
            end
        end
        if (F_en) begin
            f_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL f_en_unexpected got=1 expected=none");
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.is_eof) begin
                    bad++;
                    $display("FAIL f_en_order got=eof required=byte %h", mon_e.data);
                end else begin
                    $display("frame end");
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        Din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_t e;
        e.is_eof = 1'b0;
        e.data   = b;
        exp_q.push_back(e);
    endtask

    task automatic push_eof();
        exp_t e;
        e.is_eof = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic send_sof();
        drive(1'b0, SUB);
        drive(1'b1, 4 * SUB);
        drive(1'b0, SUB);
        drive(1'b1, 2 * SUB);
    endtask

    task automatic send_sym(input logic [1:0] v);
        logic [1:0] nv;
        int         off;
        nv  = ~v;
        off = (2 * int'(nv) + 1) * SUB;
        drive(1'b1, off);
        drive(1'b0, SUB);
        drive(1'b1, WIN - off - SUB);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_it);
        if (expect_it) push_byte(b);
        for (int i = 3; i >= 0; i--) begin
            send_sym(b[2*i +: 2]);
        end
    endtask

    task automatic send_eof(input bit expect_it);
        if (expect_it) push_eof();
        drive(1'b1, 2 * SUB);
        drive(1'b0, SUB);
        drive(1'b1, SUB);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        Din = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (Dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h required=00", Dout); end
        total++;
        if (D_en !== 1'b0) begin bad++; $display("FAIL reset_d_en got=%b required=0", D_en); end
        total++;
        if (F_en !== 1'b0) begin bad++; $display("FAIL reset_f_en got=%b required=0", F_en); end
        rst = 1'b1;
        drive(1'b1, 10);
        $display("reset checked");
    endtask

    task automatic test_byte(input logic [7:0] b);
        int d0, f0;
        d0 = d_seen;
        f0 = f_seen;
        send_sof();
        send_byte(b, 1'b1);
        send_eof(1'b1);
        drive(1'b1, 300);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL byte_%h_pending got=%0d required=0", b, exp_q.size()); end
        total++;
        if (d_seen - d0 != 1 || f_seen - f0 != 1) begin
            bad++;
            $display("FAIL byte_%h_strobes got=%0d/%0d required=1/1", b, d_seen - d0, f_seen - f0);
        end
        total++;
        if (Dout !== b) begin bad++; $display("FAIL byte_%h_hold got=%h required=%h", b, Dout, b); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int d0, f0;
        d0 = d_seen;
        f0 = f_seen;
        send_sof();
        for (int i = 0; i < 6; i++) begin
            send_byte((i % 2 == 0) ? 8'h1B : 8'hE4, 1'b1);
        end
        send_eof(1'b1);
        drive(1'b1, 300);
        total++;
        if (exp_q.size() != 0 || d_seen - d0 != 6 || f_seen - f0 != 1) begin
            bad++;
            $display("FAIL b2b_strobes got=%0d/%0d pending=%0d required=6/1 pending=0", d_seen - d0, f_seen - f0, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_bad_sof();
        int d0, f0;
        d0 = d_seen;
        f0 = f_seen;
        drive(1'b0, SUB);
        drive(1'b1, WIN - SUB);
        send_byte(8'h1B, 1'b0);
        send_eof(1'b0);
        drive(1'b1, 300);
        total++;
        if (d_seen - d0 != 0 || f_seen - f0 != 0) begin
            bad++;
            $display("FAIL bad_sof_strobes got=%0d/%0d required=0/0", d_seen - d0, f_seen - f0);
        end
        exp_q.delete();
        test_byte(8'h1B);
    endtask

    task automatic test_reset_mid();
        int d0, f0;
        d0 = d_seen;
        f0 = f_seen;
        send_sof();
        send_sym(2'b00);
        send_sym(2'b01);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (Dout !== 8'h00 || D_en !== 1'b0 || F_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h/%b/%b required=00/0/0", Dout, D_en, F_en);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 300);
        total++;
        if (d_seen - d0 != 0 || f_seen - f0 != 0) begin
            bad++;
            $display("FAIL mid_reset_strobes got=%0d/%0d required=0/0", d_seen - d0, f_seen - f0);
        end
        test_byte(8'h1B);
    endtask

    task automatic test_abort_slot4();
        int d0, f0;
        d0 = d_seen;
        f0 = f_seen;
        send_sof();
        drive(1'b1, 4 * SUB);
        drive(1'b0, SUB);
        drive(1'b1, 3 * SUB);
        drive(1'b1, 300);
        total++;
        if (d_seen - d0 != 0 || f_seen - f0 != 0) begin
            bad++;
            $display("FAIL abort_strobes got=%0d/%0d required=0/0", d_seen - d0, f_seen - f0);
        end
        exp_q.delete();
        test_byte(8'hE4);
    endtask

    initial begin
        rst = 1'b0;
        Din = 1'b1;
        @(negedge clk);
        test_reset();
        test_byte(8'h1B);
        test_byte(8'hE4);
        test_back_to_back();
        test_bad_sof();
        test_reset_mid();
        test_abort_slot4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
